// File: rtl/push_b_debounce.sv
// Four-button debouncer: 2-flop synchronizer, per-button stability filter, registered status word.
// Optional per-button 4-bit press counters are built when PUSH_B_PRESS_COUNT_EN is defined.
module push_b_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [3:0]  key_n,
  output logic [31:0] push_b_export,
  output logic [3:0]  press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  sync1_reg;
  logic [3:0]  sync2_reg;
  logic [3:0]  stable_vec;
  logic [15:0] press_cnt_bus;
  logic [3:0]  pulse_next;

  // Synchronizer idles at 1 (released) so a reset never looks like a press.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_reg <= 4'hF;
      sync2_reg <= 4'hF;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic [CW-1:0] cnt_reg;
      logic          stable_reg;
      logic          differ;
      logic          accept;

      assign differ = ((~sync2_reg[gi]) != stable_reg);
      assign accept = differ && (cnt_reg == CNT_LAST);
      assign stable_vec[gi] = stable_reg;

      always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else begin
          if (!differ || accept)
            cnt_reg <= '0;
          else
            cnt_reg <= cnt_reg + 1'b1;
          if (accept)
            stable_reg <= ~stable_reg;
        end
      end

`ifdef PUSH_B_PRESS_COUNT_EN
      logic [3:0] press_cnt_reg;

      // Counts only accepted presses (stable 0 -> 1); wraps silently.
      always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)
          press_cnt_reg <= 4'h0;
        else if (accept && !stable_reg)
          press_cnt_reg <= press_cnt_reg + 4'h1;
      end

      assign press_cnt_bus[4*gi +: 4] = press_cnt_reg;
`else
      assign press_cnt_bus[4*gi +: 4] = 4'h0;
`endif
    end
  endgenerate

  // Rising edge of the stable level relative to what was last exported.
  assign pulse_next = stable_vec & ~push_b_export[3:0];

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      push_b_export <= 32'h0;
      press_pulse   <= 4'h0;
    end else begin
      push_b_export <= {8'h00, press_cnt_bus, pulse_next, stable_vec};
      press_pulse   <= pulse_next;
    end
  end

endmodule

// File: tb/tb_push_b_debounce.sv
// Directed bench for push_b_debounce with DEBOUNCE_CYCLES=8 (latency 11 cycles).
// Counter-field expectations follow PUSH_B_PRESS_COUNT_EN.
module tb_push_b_debounce;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [3:0]  key_n;
  logic [31:0] push_b_export;
  logic [3:0]  press_pulse;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PUSH_B_PRESS_COUNT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  push_b_debounce #(.DEBOUNCE_CYCLES(8)) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .key_n        (key_n),
    .push_b_export(push_b_export),
    .press_pulse  (press_pulse)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input logic [15:0] v);
    return CEN ? {8'h00, v, 8'h00} : 32'h0;
  endfunction

  initial begin
    logic [31:0] exp;
    reset_reset_n = 1'b0;
    key_n = 4'hF;
    repeat (3) tick();
    check("reset_export", push_b_export, 32'h0);
    check("reset_pulse", {28'h0, press_pulse}, 32'h0);

    // Idle after reset
    reset_reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_export", push_b_export, 32'h0);
      check("idle_pulse", {28'h0, press_pulse}, 32'h0);
    end

    // Single press on button 0, latency 11
    key_n = 4'hE;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k < 11)       exp = 32'h0;
      else if (k == 11) exp = 32'h11 | cnt(16'h0001);
      else              exp = 32'h01 | cnt(16'h0001);
      check("press0_export", push_b_export, exp);
      check("press0_pulse", {28'h0, press_pulse}, (k == 11) ? 32'h1 : 32'h0);
    end

    // Release: no pulse, level drops after 11 cycles
    key_n = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("release0_pulse", {28'h0, press_pulse}, 32'h0);
      check("release0_export", push_b_export, ((k < 11) ? 32'h1 : 32'h0) | cnt(16'h0001));
    end

    // Bounce on button 1 every 3 cycles: must be rejected
    for (int k = 0; k < 60; k++) begin
      if (k % 3 == 0) key_n[1] = ~key_n[1];
      tick();
      check("bounce1_export", push_b_export, cnt(16'h0001));
      check("bounce1_pulse", {28'h0, press_pulse}, 32'h0);
    end
    key_n = 4'hF;
    repeat (15) tick();
    check("bounce1_settled", push_b_export, cnt(16'h0001));

    // Sixteen presses on button 2: counter 1..15,0
    for (int p = 1; p <= 16; p++) begin
      key_n = 4'hB;
      repeat (11) tick();
      check("press2_level", {31'h0, push_b_export[2]}, 32'h1);
      check("press2_pulse", {28'h0, press_pulse}, 32'h4);
      check("press2_count", {28'h0, push_b_export[19:16]}, CEN ? 32'(p % 16) : 32'h0);
      tick();
      check("press2_pulse_off", {28'h0, press_pulse}, 32'h0);
      key_n = 4'hF;
      for (int k = 0; k < 12; k++) begin
        tick();
        check("release2_pulse", {28'h0, press_pulse}, 32'h0);
      end
      check("release2_level", {31'h0, push_b_export[2]}, 32'h0);
    end

    // All four pressed in the same cycle
    key_n = 4'h0;
    repeat (10) tick();
    check("all_before", push_b_export, cnt(16'h0001));
    tick();
    check("all_export", push_b_export, 32'hFF | cnt(16'h1112));
    check("all_pulse", {28'h0, press_pulse}, 32'hF);
    tick();
    check("all_hold", push_b_export, 32'h0F | cnt(16'h1112));
    check("all_pulse_off", {28'h0, press_pulse}, 32'h0);

    key_n = 4'hF;
    repeat (12) tick();
    check("all_released", push_b_export, cnt(16'h1112));

    // Reset during a partial debounce of button 3
    key_n = 4'h7;
    repeat (5) tick();
    reset_reset_n = 1'b0;
    tick();
    check("midreset_export", push_b_export, 32'h0);
    check("midreset_pulse", {28'h0, press_pulse}, 32'h0);
    reset_reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k < 11)       exp = 32'h0;
      else if (k == 11) exp = 32'h88 | cnt(16'h1000);
      else              exp = 32'h08 | cnt(16'h1000);
      check("restart3_export", push_b_export, exp);
      check("restart3_pulse", {28'h0, press_pulse}, (k == 11) ? 32'h8 : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/push_b_debounce.md
PUSH_B_DEBOUNCE -- requirements
Module: push_b_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the consecutive stable cycles required to accept a level change (20 ms at 50 MHz; legal range 2..2^24-1).
REQ-002 Port clk_clk, input, 1, the single system clock (50 MHz); all state SHALL be clocked on its rising edge.
REQ-003 Port reset_reset_n, input, 1, synchronous active-low reset, sampled on the clk_clk rising edge.
REQ-004 Port key_n, input, 4, raw asynchronous push-button pins, low = pressed.
REQ-005 Port push_b_export, output, 32, registered status word that feeds the push-button PIO input of pcihellocore.
REQ-006 Port press_pulse, output, 4, one-cycle strobe per button on an accepted press.

Function
REQ-007 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-008 Per button: a stable state register (1 = pressed) and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-009 Counter rule: counter cleared when the inverted synchronized input equals the stable state, otherwise incremented.
REQ-010 Acceptance rule: on the cycle the counter equals DEBOUNCE_CYCLES-1 while the input still differs, the stable state SHALL toggle and the counter SHALL clear.
REQ-011 Any bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL leave the stable state unchanged.
REQ-012 End-to-end latency from a key_n transition (held clean) to push_b_export[i] changing SHALL be exactly DEBOUNCE_CYCLES+3 clk_clk cycles (2 sync, DEBOUNCE_CYCLES filter, 1 output register).
REQ-013 press_pulse[i] SHALL be high for exactly one cycle, aligned with push_b_export[i] rising; releases produce no pulse.
REQ-014 Status word fields: [3:0] stable pressed levels, [7:4] copy of press_pulse, [23:8] press counters (see Configuration), [31:24] constant 0.
REQ-015 Press counter i occupies bits [8+4i+3:8+4i]; it increments by 1 on each accepted press and wraps 15 -> 0 with no flag.
REQ-016 Buttons SHALL be fully independent; simultaneous presses or releases on several buttons SHALL each be accepted in the same cycle with no priority.
REQ-017 A key_n value of 4'b0000 held from reset SHALL be accepted as four presses after DEBOUNCE_CYCLES+3 cycles from reset release.

Reset
REQ-018 While reset_reset_n is low at a clock edge: synchronizer flops SHALL load 1 (released), stable states 0, filter counters 0, press counters 0, press_pulse 4'h0, push_b_export 32'h0.
REQ-019 Reset asserted mid-debounce SHALL discard the partial count; filtering restarts from zero after release.
REQ-020 No output SHALL change on a reset_reset_n edge alone; all effects appear at the next clk_clk rising edge.

Configuration
REQ-021 Macro PUSH_B_PRESS_COUNT_EN: when defined, the four 4-bit press counters SHALL be implemented and driven onto push_b_export[23:8].
REQ-022 When PUSH_B_PRESS_COUNT_EN is undefined, no counter flops SHALL be built and push_b_export[23:8] SHALL read constant 0; all other behaviour is unchanged.

Verification (bench uses DEBOUNCE_CYCLES=8)
REQ-023 Reset, key_n=4'hF for 20 cycles -> push_b_export=32'h0 and press_pulse=0 throughout.
REQ-024 key_n[0] driven low and held -> push_b_export[0]=1 exactly 11 cycles later, with press_pulse[0] and bit 4 high for that one cycle only. With the macro defined, bits [11:8]=1 from that cycle on.
REQ-025 key_n[1] toggled every 3 cycles for 60 cycles then held high -> push_b_export[1] stays 0 and press_pulse[1] is never asserted.
REQ-026 Sixteen clean presses and releases on key_n[2], macro defined -> bits [19:16] go 1,2,...,15,0. Releases produce no press_pulse.
REQ-027 key_n driven 4'hF -> 4'h0 in one cycle -> push_b_export[3:0]=4'hF and press_pulse=4'hF in the same cycle.
REQ-028 Reset asserted 5 cycles into a key_n[3] press, released, key held low -> push_b_export[3] rises 11 cycles after reset release. Repeat with the macro undefined -> bits [23:8] always 0.
